// File: rtl/irq_pkg.sv
// Shared encodings for the interrupt controller: FSM states, IO register offsets and source indices.
// Also holds the vector address helper shared by the controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CLR     = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_t;

  localparam logic [7:0] OFF_IE   = 8'd0;
  localparam logic [7:0] OFF_PEND = 8'd1;
  localparam logic [7:0] OFF_STAT = 8'd2;

  localparam logic [1:0] SRC_TOP    = 2'd0;
  localparam logic [1:0] SRC_MATCH0 = 2'd1;
  localparam logic [1:0] SRC_MATCH1 = 2'd2;
  localparam logic [1:0] SRC_BLANK  = 2'd3;

  // Vector addresses wrap at 16 bits by construction.
  function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [1:0]  idx);
    logic [15:0] offs;
    offs = stride * {14'd0, idx};
    return base + offs;
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority 4-to-2 encoder; bit 0 wins. Purely combinational, no backpressure.
module irq_priority_enc (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    idx = 2'd0;
    vld = 1'b1;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
    else             vld = 1'b0;
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller with req/ack/reti CPU handshake and IO-bus registers.
// Latency: flag to irq_req 1 cycle, read data 1 cycle; the CPU holds off via ack timing only.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [7:0]  IRQ_ADDRESS   = 8'h90,
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic [7:0]  address,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  input  logic        top_flag,
  input  logic        match0_flag,
  input  logic        match1_flag,
  input  logic        blanking_start_interrupt_flag,
  output logic        top_flag_clr,
  output logic        match0_flag_clr,
  output logic        match1_flag_clr,
  output logic        blanking_start_interrupt_flag_clr,
  output logic        irq_req,
  output logic [15:0] irq_vector,
  input  logic        irq_ack,
  input  logic        reti
);

  irq_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        gie_q, gie_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  sw_clr_q, sw_clr_d;
  logic [7:0]  dout_q, dout_d;

  logic [3:0]  flags;
  logic [3:0]  pend;
  logic [3:0]  fsm_clr;
  logic [3:0]  clr_all;
  logic [1:0]  enc_idx;
  logic        enc_vld;
  logic        sel_ie, sel_pend, sel_stat;
  logic        unused_din;

  assign unused_din = ^din[6:4];

  assign flags = {blanking_start_interrupt_flag, match1_flag, match0_flag, top_flag};
  assign pend  = flags & mask_q & {4{gie_q}};

  assign sel_ie   = (address == 8'(IRQ_ADDRESS + OFF_IE));
  assign sel_pend = (address == 8'(IRQ_ADDRESS + OFF_PEND));
  assign sel_stat = (address == 8'(IRQ_ADDRESS + OFF_STAT));

  irq_priority_enc u_enc (
    .req (pend),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  // Once in REQ the index is locked; only ack or withdrawal of that source moves on.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fsm_clr = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          state_d = ST_REQ;
          idx_d   = enc_idx;
        end
      end
      ST_REQ: begin
        if (irq_ack)           state_d = ST_CLR;
        else if (!pend[idx_q]) state_d = ST_IDLE;
      end
      ST_CLR: begin
        fsm_clr[idx_q] = 1'b1;
        state_d        = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gie_d    = gie_q;
    mask_d   = mask_q;
    sw_clr_d = 4'd0;
    dout_d   = 8'd0;
    if (w_en && sel_ie) begin
      gie_d  = din[7];
      mask_d = din[3:0];
    end
    if (w_en && sel_pend) sw_clr_d = din[3:0];
    if (r_en) begin
      if (sel_ie)        dout_d = {gie_q, 3'b000, mask_q};
      else if (sel_pend) dout_d = {4'b0000, flags};
      else if (sel_stat) dout_d = {(state_q == ST_CLR) || (state_q == ST_SERVICE), 4'b0000,
                                   state_q == ST_REQ, idx_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      gie_q    <= 1'b0;
      mask_q   <= 4'd0;
      sw_clr_q <= 4'd0;
      dout_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gie_q    <= gie_d;
      mask_q   <= mask_d;
      sw_clr_q <= sw_clr_d;
      dout_q   <= dout_d;
    end
  end

  // Hardware and software clears merge into a single pulse per source.
  assign clr_all = fsm_clr | sw_clr_q;

  assign top_flag_clr                      = clr_all[SRC_TOP];
  assign match0_flag_clr                   = clr_all[SRC_MATCH0];
  assign match1_flag_clr                   = clr_all[SRC_MATCH1];
  assign blanking_start_interrupt_flag_clr = clr_all[SRC_BLANK];

  assign irq_req    = (state_q == ST_REQ);
  assign irq_vector = irq_req ? vector_addr(VECTOR_BASE, VECTOR_STRIDE, idx_q) : 16'h0000;
  assign dout       = dout_q;

endmodule
